// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC fetches, pairs in-order memory responses with their slots, feeds decode.
// Latency: memory response to decode valid is 1 cycle, or 0 cycles when FETCH_BYPASS_EN is defined.
// Backpressure: decode stalls fill the slot ring; requests and pc_en_o stop while all DEPTH slots are reserved.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_en_o,
  input  logic             flush_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] P_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  // Ring pointers carry a wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    r_alloc;
  logic [PW-1:0]    r_fill;
  logic [PW-1:0]    r_rd;
  // Responses still owed by memory for fetches discarded by a redirect.
  logic [PW-1:0]    r_drop;
  logic [WIDTH-1:0] r_pc  [DEPTH];
  logic [WIDTH-1:0] r_ins [DEPTH];

  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_pend;
  logic          w_full;
  logic          w_req;
  logic          w_resp_acc;
  logic          w_drop_rsp;
  logic          w_valid;
  logic          w_xfer;
  logic          w_slot_wr;
  logic [AW-1:0] w_alloc_idx;
  logic [AW-1:0] w_fill_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_occ       = r_alloc - r_rd;
  assign w_pend      = r_alloc - r_fill;
  // Full looks only at registered pointers, so a same-cycle transfer does not reopen a slot early.
  assign w_full      = (w_occ == P_DEPTH);
  assign w_req       = rst_n & ~w_full & ~flush_i;
  assign w_resp_acc  = imem_rvalid_i & (r_drop == '0);
  assign w_drop_rsp  = imem_rvalid_i & (r_drop != '0);
  assign w_alloc_idx = r_alloc[AW-1:0];
  assign w_fill_idx  = r_fill[AW-1:0];
  assign w_rd_idx    = r_rd[AW-1:0];
  assign w_xfer      = w_valid & instr_ready_i;

  assign imem_req_o    = w_req;
  assign imem_addr_o   = pc_i;
  assign pc_en_o       = w_req;
  assign instr_valid_o = w_valid;
  assign instr_pc_o    = r_pc[w_rd_idx];

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  // With no filled entry waiting, a live response goes straight to decode.
  assign w_byp     = rst_n & w_resp_acc & (r_fill == r_rd);
  assign w_valid   = rst_n & ~flush_i & ((r_fill != r_rd) | w_byp);
  assign instr_o   = w_byp ? imem_rdata_i : r_ins[w_rd_idx];
  // A bypassed response consumed by decode never needs to land in its slot.
  assign w_slot_wr = w_resp_acc & ~(w_byp & w_xfer);
`else
  assign w_valid   = rst_n & ~flush_i & (r_fill != r_rd);
  assign instr_o   = r_ins[w_rd_idx];
  assign w_slot_wr = w_resp_acc;
`endif

  // Pointer and drop-count update; a redirect empties the ring and remembers what memory still owes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_rd    <= '0;
      r_drop  <= '0;
    end else if (flush_i) begin
      r_alloc <= '0;
      r_fill  <= '0;
      r_rd    <= '0;
      // Any response this cycle either was accepted or retires one owed drop; both reduce the debt by one.
      r_drop  <= r_drop + w_pend - PW'(imem_rvalid_i);
    end else begin
      r_alloc <= r_alloc + PW'(w_req);
      r_fill  <= r_fill + PW'(w_resp_acc);
      r_rd    <= r_rd + PW'(w_xfer);
      if (w_drop_rsp) begin
        r_drop <= r_drop - P_ONE;
      end
    end
  end

  // Slot storage: PC captured at request time, instruction captured at response time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]  <= '0;
        r_ins[i] <= '0;
      end
    end else begin
      if (w_req) begin
        r_pc[w_alloc_idx] <= pc_i;
      end
      if (w_slot_wr) begin
        r_ins[w_fill_idx] <= imem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model with configurable latency, PC register model, in-order scoreboard.
// Table-driven backpressure sequence plus hand-written streaming, flush and async-reset sequences.
// Works for both default and FETCH_BYPASS_EN builds.
module tb_fetch_queue;

  localparam int W = 32;
  localparam int D = 4;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] pc_i;
  logic         pc_en_o;
  logic         flush_i;
  logic         imem_req_o;
  logic [W-1:0] imem_addr_o;
  logic         imem_rvalid_i;
  logic [W-1:0] imem_rdata_i;
  logic         instr_valid_o;
  logic         instr_ready_i;
  logic [W-1:0] instr_o;
  logic [W-1:0] instr_pc_o;

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .pc_en_o      (pc_en_o),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o)
  );

  typedef struct { logic [31:0] addr; int t; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld_nb;
    logic        vld_bp;
    logic [31:0] pc;
  } vec_t;

  mreq_t mq[$];
  exp_t  sb[$];
  vec_t  tv[10];

  int          cyc = 0;
  int          mem_lat = 1;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  logic [31:0] flush_tgt = '0;
  logic        smp_valid, smp_req, smp_pcen;
  logic [31:0] smp_instr, smp_pc, smp_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endfunction

  // Present the head memory response once its latency has elapsed.
  task automatic drive_mem();
    if (mq.size() > 0 && cyc >= mq[0].t + mem_lat) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
  endtask

  // One clock: called just after a falling edge with instr_ready_i / flush_i already set.
  task automatic cycle();
    logic        req, rsp, fl;
    logic [31:0] addr;
    exp_t        e;
    drive_mem();
    #1;
    smp_valid = instr_valid_o;
    smp_req   = imem_req_o;
    smp_pcen  = pc_en_o;
    smp_instr = instr_o;
    smp_pc    = instr_pc_o;
    smp_addr  = imem_addr_o;
    if (instr_valid_o && instr_ready_i) begin
      n_xfer++;
      if (sb.size() == 0) begin
        timeout("sb_unexpected_transfer");
      end else begin
        e = sb.pop_front();
        chk("xfer_instr", instr_o, e.instr);
        chk("xfer_pc", instr_pc_o, e.pc);
      end
    end
    if (imem_req_o) chk("req_addr", imem_addr_o, pc_i);
    req  = imem_req_o;
    addr = imem_addr_o;
    rsp  = imem_rvalid_i;
    fl   = flush_i;
    @(posedge clk);
    if (rsp) void'(mq.pop_front());
    if (fl) sb.delete();
    if (req) begin
      mq.push_back('{addr, cyc});
      sb.push_back('{mem_data(addr), addr});
    end
    cyc++;
    @(negedge clk);
    flush_i = 1'b0;
    if (fl) pc_i = flush_tgt;
    else if (req) pc_i = pc_i + 32'd4;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    flush_i       = 1'b0;
    instr_ready_i = 1'b0;
    pc_i          = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    mq.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_valid", instr_valid_o, 1'b0);
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_pcen", pc_en_o, 1'b0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_instr_pc", instr_pc_o, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   first;
    logic exp_v;

    tv[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00};
    tv[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b1, 32'h00};
    tv[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 1'b1, 32'h00};
    tv[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h00};
    tv[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00};
    tv[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00};
    tv[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h04};
    tv[7] = '{1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h08};
    tv[8] = '{1'b1, 1'b1, 32'h18, 1'b1, 1'b1, 32'h0C};
    tv[9] = '{1'b1, 1'b1, 32'h1C, 1'b1, 1'b1, 32'h10};

    // Streaming with 1-cycle memory, decode always ready.
    do_reset();
    mem_lat       = 1;
    instr_ready_i = 1'b1;
    n_xfer        = 0;
    first         = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk1("stream_req", smp_req, 1'b1);
      if (smp_valid && first < 0) first = i;
`ifdef FETCH_BYPASS_EN
      if (i == 1) begin
        chk("bypass_instr", smp_instr, 32'h0050_0093);
        chk("bypass_rd", 32'(dut.r_rd), 32'd1);
        chk("bypass_fill", 32'(dut.r_fill), 32'd1);
      end
`endif
    end
    chk("stream_first_valid", first, BYP ? 32'd1 : 32'd2);
    chk("stream_xfers", n_xfer, BYP ? 32'd11 : 32'd10);

    // Backpressure table: ready low until the ring fills, then released.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      instr_ready_i = tv[i].rdy;
      cycle();
      chk1($sformatf("bp_req[%0d]", i), smp_req, tv[i].req);
      chk1($sformatf("bp_pcen[%0d]", i), smp_pcen, tv[i].req);
      if (tv[i].req) chk($sformatf("bp_addr[%0d]", i), smp_addr, tv[i].addr);
      exp_v = BYP ? tv[i].vld_bp : tv[i].vld_nb;
      chk1($sformatf("bp_valid[%0d]", i), smp_valid, exp_v);
      if (exp_v) chk($sformatf("bp_pc[%0d]", i), smp_pc, tv[i].pc);
    end

    // Flush with two fetches outstanding; their responses must vanish.
    do_reset();
    mem_lat       = 3;
    instr_ready_i = 1'b1;
    cycle();
    cycle();
    flush_tgt = 32'h100;
    flush_i   = 1'b1;
    cycle();
    chk1("fl_req", smp_req, 1'b0);
    chk1("fl_valid", smp_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk1($sformatf("fl_drop_valid[%0d]", k), smp_valid, 1'b0);
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle();
      if (smp_valid) begin
        got = 1'b1;
        chk("fl_first_pc", smp_pc, 32'h100);
      end
    end
    if (!got) timeout("fl_first_pc");

    // Flush in the same cycle as a response and a ready decode, one fetch pending.
    do_reset();
    mem_lat       = 1;
    instr_ready_i = 1'b1;
    cycle();
    flush_tgt = 32'h200;
    flush_i   = 1'b1;
    cycle();
    chk1("co_valid", smp_valid, 1'b0);
    chk1("co_req", smp_req, 1'b0);
    chk("co_drop", 32'(dut.r_drop), 32'd0);
    chk("co_alloc", 32'(dut.r_alloc), 32'd0);
    chk("co_rd", 32'(dut.r_rd), 32'd0);
    cycle();
    chk1("co_empty_valid", smp_valid, 1'b0);
    chk1("co_req_after", smp_req, 1'b1);
    chk("co_addr_after", smp_addr, 32'h200);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle();
      if (smp_valid) begin
        got = 1'b1;
        chk("co_first_pc", smp_pc, 32'h200);
      end
    end
    if (!got) timeout("co_first_pc");

    // Asynchronous reset with three slots occupied.
    do_reset();
    mem_lat       = 1;
    instr_ready_i = 1'b0;
    repeat (3) cycle();
    chk1("ar_valid_pre", smp_valid, 1'b1);
    chk("ar_alloc_pre", 32'(dut.r_alloc), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("ar_valid", instr_valid_o, 1'b0);
    chk1("ar_req", imem_req_o, 1'b0);
    chk1("ar_pcen", pc_en_o, 1'b0);
    chk("ar_alloc", 32'(dut.r_alloc), 32'd0);
    chk("ar_fill", 32'(dut.r_fill), 32'd0);
    chk("ar_rd", 32'(dut.r_rd), 32'd0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
